// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter for the shared main-memory port.
// Tie policy: define ARB_RR_EN for round-robin, otherwise D-cache wins every tie.
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic          i_wr,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          i_gnt,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic [DW-1:0] d_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic [3:0]    mem_busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DRAIN} state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(TIMEOUT - 1);

  state_t     state_q, state_d, arb_state;
  logic       last_q, last_d;            // 1: D-cache was the most recent owner
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       err_q, err_d;
  logic       i_gnt_q, d_gnt_q;
  logic       d_wins_tie, pick_d;

`ifdef ARB_RR_EN
  assign d_wins_tie = ~last_q;
`else
  // last is still maintained here so both builds share the same state.
  assign d_wins_tie = last_q | 1'b1;
`endif

  assign pick_d    = d_req & (~i_req | d_wins_tie);
  assign arb_state = (i_req | d_req) ? (pick_d ? GNT_D : GNT_I) : IDLE;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE:  state_d = arb_state;
      GNT_I: if (!i_req) begin
               state_d = DRAIN;
               last_d  = 1'b0;
             end
      GNT_D: if (!d_req) begin
               state_d = DRAIN;
               last_d  = 1'b1;
             end
      DRAIN: if (mem_busy == 4'b0000) state_d = arb_state;
      default: state_d = IDLE;
    endcase

    if (state_d == GNT_I || state_d == GNT_D) begin
      if (state_d != state_q)
        hold_cnt_d = 8'd0;
      else if (hold_cnt_q != 8'hFF)
        hold_cnt_d = hold_cnt_q + 8'd1;
    end

    // err rises in the same cycle hold_cnt reaches its limit.
    err_d = err_q | (((state_d == GNT_I) || (state_d == GNT_D)) && (hold_cnt_d == HOLD_LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b0;
      hold_cnt_q <= 8'd0;
      err_q      <= 1'b0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      err_q      <= err_d;
      i_gnt_q    <= (state_d == GNT_I);
      d_gnt_q    <= (state_d == GNT_D);
    end
  end

  assign i_gnt = i_gnt_q;
  assign d_gnt = d_gnt_q;
  assign err   = err_q;

  // Memory port mux keyed off the registered grants, so reset clears it at once.
  assign mem_rd    = (i_gnt_q & i_req & ~i_wr) | (d_gnt_q & d_req & ~d_wr);
  assign mem_wr    = (i_gnt_q & i_req &  i_wr) | (d_gnt_q & d_req &  d_wr);
  assign mem_addr  = i_gnt_q ? i_addr  : (d_gnt_q ? d_addr  : '0);
  assign mem_wdata = i_gnt_q ? i_wdata : (d_gnt_q ? d_wdata : '0);
  assign i_rdata   = i_gnt_q ? mem_rdata : '0;
  assign d_rdata   = d_gnt_q ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus hand-written multi-cycle sequences.
// Follows the DUT build: define ARB_RR_EN for both to check the round-robin variant.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_wr, d_req, d_wr;
  logic [15:0] i_addr, i_wdata, d_addr, d_wdata, mem_rdata;
  logic [3:0]  mem_busy;
  logic        i_gnt, d_gnt, mem_rd, mem_wr, err;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_gnt(i_gnt), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .err(err)
  );

  typedef struct {
    logic        ireq, iwr;
    logic [15:0] iaddr, iwdata;
    logic        dreq, dwr;
    logic [15:0] daddr, dwdata;
    logic [15:0] rdata;
    logic [3:0]  busy;
    logic [3:0]  eflags;   // {i_gnt, d_gnt, mem_rd, mem_wr}
    logic [15:0] eaddr, ewdata, eird, edrd;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic idle_inputs();
    i_req = 0; i_wr = 0; i_addr = 0; i_wdata = 0;
    d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0; mem_busy = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 4'b0000,
                4'b1010, 16'h0040, 16'h0000, 16'h1234, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 16'h0041, 16'hAAAA, 1'b1, 1'b0, 16'h0999, 16'h5555, 16'h5678, 4'b0000,
                4'b1001, 16'h0041, 16'hAAAA, 16'h5678, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 16'h0041, 16'hAAAA, 1'b1, 1'b0, 16'h0999, 16'h5555, 16'h5678, 4'b0010,
                4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[3] = vecs[2];
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0200, 16'hBEEF, 16'h0F0F, 4'b0000,
                4'b0101, 16'h0200, 16'hBEEF, 16'h0000, 16'h0F0F};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'hBEEF, 16'h0F0F, 4'b1111,
                4'b0110, 16'h0200, 16'hBEEF, 16'h0000, 16'h0F0F};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0F0F, 4'b0000,
                4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[7] = vecs[6];
`ifdef ARB_RR_EN
    vecs[8] = '{1'b1, 1'b0, 16'h0300, 16'h1111, 1'b1, 1'b0, 16'h0400, 16'h2222, 16'h7777, 4'b0000,
                4'b1010, 16'h0300, 16'h1111, 16'h7777, 16'h0000};
`else
    vecs[8] = '{1'b1, 1'b0, 16'h0300, 16'h1111, 1'b1, 1'b0, 16'h0400, 16'h2222, 16'h7777, 4'b0000,
                4'b0110, 16'h0400, 16'h2222, 16'h0000, 16'h7777};
`endif

    // Reset held with both requests high, then first grant goes to D
    idle_inputs();
    rst_n = 0;
    i_req = 1; d_req = 1;
    tick();
    tick();
    chk("reset_outputs", {64'd0, i_gnt, d_gnt, mem_rd, mem_wr}, 68'd0);
    chk("reset_err", {67'd0, err}, 68'd0);
    rst_n = 1;
    tick();
    chk("first_tie_to_d", {64'd0, i_gnt, d_gnt, mem_rd, mem_wr}, {64'd0, 4'b0110});

    // Vector table
    apply_reset();
    for (int v = 0; v < 9; v++) begin
      i_req = vecs[v].ireq; i_wr = vecs[v].iwr; i_addr = vecs[v].iaddr; i_wdata = vecs[v].iwdata;
      d_req = vecs[v].dreq; d_wr = vecs[v].dwr; d_addr = vecs[v].daddr; d_wdata = vecs[v].dwdata;
      mem_rdata = vecs[v].rdata; mem_busy = vecs[v].busy;
      tick();
      chk($sformatf("vec%0d", v),
          {i_gnt, d_gnt, mem_rd, mem_wr, mem_addr, mem_wdata, i_rdata, d_rdata},
          {vecs[v].eflags, vecs[v].eaddr, vecs[v].ewdata, vecs[v].eird, vecs[v].edrd});
    end

    // Back-to-back 8-cycle bursts with both caches always asking again
    apply_reset();
    i_req = 1; d_req = 1;
    for (int b = 0; b < 4; b++) begin
      int w;
      logic [1:0] exp_owner;
      w = 0;
      do begin
        tick();
        w++;
      end while (!(i_gnt | d_gnt) && w < 20);
`ifdef ARB_RR_EN
      exp_owner = (b % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_owner = 2'b01;
`endif
      chk($sformatf("burst%0d_owner", b), {66'd0, i_gnt, d_gnt}, {66'd0, exp_owner});
      repeat (8) tick();
      if (d_gnt) d_req = 0;
      else if (i_gnt) i_req = 0;
      tick();
      i_req = 1; d_req = 1;
    end

    // Grant held past the timeout
    apply_reset();
    d_req = 1;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (k == 63) chk("err_before_limit", {66'd0, err, d_gnt}, {66'd0, 2'b01});
      if (k == 64) chk("err_at_limit", {66'd0, err, d_gnt}, {66'd0, 2'b11});
      if (k == 70) chk("grant_kept_after_err", {66'd0, err, d_gnt}, {66'd0, 2'b11});
    end
    d_req = 0;
    repeat (3) tick();
    chk("err_sticky", {65'd0, err, d_gnt, i_gnt}, {65'd0, 3'b100});

    // Asynchronous reset in the middle of a write
    d_req = 1; d_wr = 1; d_addr = 16'h0123; d_wdata = 16'h4567;
    tick();
    chk("write_granted", {48'd0, d_gnt, mem_wr, err, mem_addr, 1'b0}, {48'd0, 3'b111, 16'h0123, 1'b0});
    #2;
    rst_n = 0;
    #1;
    chk("async_reset_drop", {48'd0, d_gnt, mem_wr, err, mem_addr, 1'b0}, 68'd0);
    tick();
    rst_n = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
